fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Write-port arbiter for the shared capture FIFO, running in the front-end clock domain. It merges up to four front-end capture sources (valid/ready requesters) into the single FIFO write port using round-robin arbitration. It applies back-pressure from the FIFO's programmable-full threshold so that no word is ever presented to a full FIFO. It keeps a saturating stall counter for register readback.

Parameters:
NUM_REQ, 2, number of requesters; legal range 2..4.
DW, 18, FIFO data width; matches the capture FIFO word.
CNT_W, 16, width of the stall counter.

Ports:
fe_clk  in  1  front-end clock; the only clock in the block.
reset_i  in  1  reset; asynchronous, active-high.
I_enable  in  1  arbitration enable (from register block, already in fe_clk domain).
I_clear_stats  in  1  single-cycle pulse; clears O_stall_count.
I_req_valid  in  NUM_REQ  per-requester word valid.
I_req_data  in  NUM_REQ*DW  per-requester word; requester k occupies bits [k*DW +: DW].
O_req_ready  out  NUM_REQ  one-hot grant; requester k's word is accepted when valid[k] & ready[k].
I_fifo_full  in  1  FIFO full flag (write side).
I_fifo_prog_full  in  1  FIFO programmable-full flag (write side).
O_fifo_wr  out  1  FIFO write enable.
O_fifo_data  out  DW  FIFO write data.
O_last_grant  out  2  index of the most recently accepted requester.
O_state  out  2  FSM state, for debug readback.
O_stall_count  out  CNT_W  saturating count of blocked cycles.

Behaviour:
- Reset (async assert, sync release): O_fifo_wr=0, O_fifo_data=0, O_last_grant=NUM_REQ-1 (so requester 0 wins first), O_state=IDLE, O_stall_count=0, O_req_ready=0.
- Blocking condition: blk = I_fifo_full | I_fifo_prog_full.
- FSM, 2-bit encoding: IDLE=0, RUN=1, BLOCKED=2.
  - IDLE -> RUN when I_enable=1.
  - RUN -> BLOCKED when blk=1.
  - BLOCKED -> RUN when blk=0 and I_enable=1.
  - RUN or BLOCKED -> IDLE when I_enable=0; this has priority over the blk transitions.
  - A write already registered still issues on the following cycle regardless of the state change.
- Grant (combinational):
  - O_req_ready is nonzero only when state==RUN, blk=0 and I_enable=1.
  - The winner is the first requester with valid=1, searching from O_last_grant+1 modulo NUM_REQ upward.
  - At most one bit of O_req_ready is set.
  - Ready may be driven high to a non-valid requester only if no requester is valid; ready is 0 when no requester is valid.
- Accept: on a clock edge where valid[k]&ready[k]:
  - O_fifo_wr<=1, O_fifo_data<=selected word, O_last_grant<=k.
  - Otherwise O_fifo_wr<=0 and O_fifo_data holds its value.
- Latency: exactly 1 cycle from accept edge to O_fifo_wr high. Sustained throughput is 1 word/cycle across all requesters.
- The prog_full threshold must leave at least 2 free entries (registered write + one-cycle flag delay). Given that, O_fifo_wr is never asserted while I_fifo_full=1. A bench assertion checks this.
- Stall counter:
  - Increments when (|I_req_valid) & I_enable & (blk | state==BLOCKED).
  - Saturates at 2^CNT_W-1.
  - I_clear_stats takes priority over an increment in the same cycle (result is 0).
- Fairness: with all requesters continuously valid and no blocking, grants rotate 0,1,..,NUM_REQ-1,0,...
- Requester data width rules: DW bits are passed unchanged unless the optional feature is enabled.
- Reset mid-operation: the pending write is discarded (O_fifo_wr forced to 0 immediately); the round-robin pointer returns to its reset value.

Optional Feature:
Macro FIFO_ARB_TAG_EN.
- Defined: O_fifo_data[DW-1:DW-2] is replaced by the 2-bit requester index; O_fifo_data[DW-3:0] comes from the requester's low DW-2 bits, and the requester's top 2 bits are dropped. This lets the host demultiplex sources.
- Not defined: all DW bits are passed through unchanged; there is no tag and no index logic in the data path.

Test Plan:
- Reset with all requesters valid, I_enable=1, blk=0 → first O_fifo_wr one cycle after first accept carries requester 0 data; O_state goes 0→1.
- NUM_REQ=3, all valid continuously for 9 cycles → 9 writes; O_last_grant sequence 0,1,2,0,1,2,0,1,2; O_req_ready always one-hot.
- Only requester 1 valid, data 0x2ABCD for 4 cycles → 4 consecutive writes of 0x2ABCD; ready[0] and ready[2] stay 0.
- Assert I_fifo_prog_full for 10 cycles with requester 0 valid → ready=0; O_state=2; O_stall_count advances by 10; no O_fifo_wr while I_fifo_full=1. On deassert, writes resume within 2 cycles.
- Drop I_enable mid-stream after an accept → exactly one trailing O_fifo_wr, then O_state=0 and ready=0. Pulse I_clear_stats on the same cycle as a stall → O_stall_count=0.
- With FIFO_ARB_TAG_EN, requester 2 sends 0x3FFFF → O_fifo_data=0x2FFFF. Without the macro → O_fifo_data=0x3FFFF.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter merging NUM_REQ capture sources into one FIFO write port.
// Optional macro FIFO_ARB_TAG_EN replaces the top two data bits with the source index.
module fifo_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 18,
  parameter int CNT_W   = 16
) (
  input  logic                  fe_clk,
  input  logic                  reset_i,
  input  logic                  I_enable,
  input  logic                  I_clear_stats,
  input  logic [NUM_REQ-1:0]    I_req_valid,
  input  logic [NUM_REQ*DW-1:0] I_req_data,
  output logic [NUM_REQ-1:0]    O_req_ready,
  input  logic                  I_fifo_full,
  input  logic                  I_fifo_prog_full,
  output logic                  O_fifo_wr,
  output logic [DW-1:0]         O_fifo_data,
  output logic [1:0]            O_last_grant,
  output logic [1:0]            O_state,
  output logic [CNT_W-1:0]      O_stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_BLOCKED = 2'd2
  } state_e;

  state_e               state_q;
  logic                 wr_q;
  logic [DW-1:0]        data_q;
  logic [1:0]           last_grant_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;

  logic                 blk;
  logic                 grant_any;
  logic [1:0]           grant_idx;
  logic [NUM_REQ-1:0]   grant_oh;
  logic [DW-1:0]        data_sel;
  logic [DW-1:0]        wr_word;
  logic                 stall_inc;
  int                   cand;

  assign blk = I_fifo_full | I_fifo_prog_full;

  // Round-robin search starting just after the last accepted requester.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 0;
    if ((state_q == ST_RUN) && !blk && I_enable) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = int'(last_grant_q) + i + 1;
        if (cand >= NUM_REQ) begin
          cand = cand - NUM_REQ;
        end else begin
          cand = cand;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!grant_any && I_req_valid[k] && (k == cand)) begin
            grant_any = 1'b1;
            grant_idx = 2'(k);
          end else begin
            grant_any = grant_any;
          end
        end
      end
    end else begin
      grant_any = 1'b0;
    end
  end

  // One-hot ready and the selected requester word.
  always_comb begin
    grant_oh = '0;
    data_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      grant_oh[k] = grant_any && (grant_idx == 2'(k));
      if (grant_oh[k]) begin
        data_sel = I_req_data[k*DW +: DW];
      end else begin
        data_sel = data_sel;
      end
    end
  end

`ifdef FIFO_ARB_TAG_EN
  assign wr_word = {grant_idx, data_sel[DW-3:0]};
`else
  assign wr_word = data_sel;
`endif

  // Saturating stall counter; a clear wins over a same-cycle increment.
  always_comb begin
    stall_inc = (|I_req_valid) & I_enable & (blk | (state_q == ST_BLOCKED));
    if (I_clear_stats) begin
      cnt_d = '0;
    end else if (stall_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Control FSM; disabling takes priority over the blocking transitions.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_enable) state_q <= ST_RUN;
          else          state_q <= ST_IDLE;
        end
        ST_RUN: begin
          if (!I_enable) state_q <= ST_IDLE;
          else if (blk)  state_q <= ST_BLOCKED;
          else           state_q <= ST_RUN;
        end
        ST_BLOCKED: begin
          if (!I_enable) state_q <= ST_IDLE;
          else if (!blk) state_q <= ST_RUN;
          else           state_q <= ST_BLOCKED;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Registered write port, round-robin pointer and stall counter.
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_q         <= 1'b0;
      data_q       <= '0;
      last_grant_q <= 2'(NUM_REQ - 1);
      cnt_q        <= '0;
    end else begin
      wr_q  <= grant_any;
      cnt_q <= cnt_d;
      if (grant_any) begin
        data_q       <= wr_word;
        last_grant_q <= grant_idx;
      end else begin
        data_q       <= data_q;
        last_grant_q <= last_grant_q;
      end
    end
  end

  assign O_req_ready   = grant_oh;
  assign O_fifo_wr     = wr_q;
  assign O_fifo_data   = data_q;
  assign O_last_grant  = last_grant_q;
  assign O_state       = state_q;
  assign O_stall_count = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Table-driven bench for fifo_wr_arbiter (NUM_REQ=3, DW=18, CNT_W=5).
module tb_fifo_wr_arbiter;

  localparam int NR = 3;
  localparam int DW = 18;
  localparam int CW = 5;

  logic             fe_clk = 1'b0;
  logic             reset_i;
  logic             I_enable, I_clear_stats, I_fifo_full, I_fifo_prog_full;
  logic [NR-1:0]    I_req_valid;
  logic [NR*DW-1:0] I_req_data;
  logic [NR-1:0]    O_req_ready;
  logic             O_fifo_wr;
  logic [DW-1:0]    O_fifo_data;
  logic [1:0]       O_last_grant, O_state;
  logic [CW-1:0]    O_stall_count;

  int total = 0;
  int bad   = 0;

  localparam logic [17:0] D0 = 18'h00A01;
  localparam logic [17:0] D1 = 18'h2ABCD;
  localparam logic [17:0] D2 = 18'h3FFFF;

  typedef struct {
    string       name;
    logic        en, clr;
    logic [2:0]  vld;
    logic        pf, full;
    logic [2:0]  rdy;
    logic        wr;
    logic [17:0] dat;
    logic [1:0]  lg, st;
    logic [4:0]  cnt;
  } vec_t;

  vec_t vq[$];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DW(DW), .CNT_W(CW)) dut (
    .fe_clk(fe_clk), .reset_i(reset_i), .I_enable(I_enable), .I_clear_stats(I_clear_stats),
    .I_req_valid(I_req_valid), .I_req_data(I_req_data), .O_req_ready(O_req_ready),
    .I_fifo_full(I_fifo_full), .I_fifo_prog_full(I_fifo_prog_full), .O_fifo_wr(O_fifo_wr),
    .O_fifo_data(O_fifo_data), .O_last_grant(O_last_grant), .O_state(O_state),
    .O_stall_count(O_stall_count)
  );

  always #5 fe_clk = ~fe_clk;

  function automatic logic [17:0] xw(input logic [1:0] k, input logic [17:0] w);
`ifdef FIFO_ARB_TAG_EN
    return {k, w[15:0]};
`else
    return w;
`endif
  endfunction

  function automatic vec_t mk(input string n, input logic en, input logic clr, input logic [2:0] vld,
                              input logic pf, input logic full, input logic [2:0] rdy, input logic wr,
                              input logic [17:0] dat, input logic [1:0] lg, input logic [1:0] st,
                              input logic [4:0] cnt);
    vec_t v;
    v.name = n; v.en = en; v.clr = clr; v.vld = vld; v.pf = pf; v.full = full;
    v.rdy = rdy; v.wr = wr; v.dat = dat; v.lg = lg; v.st = st; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  // Called at a negedge: drive, check ready, clock once, check registered outputs.
  task automatic apply(input vec_t v);
    I_enable = v.en; I_clear_stats = v.clr; I_req_valid = v.vld;
    I_fifo_prog_full = v.pf; I_fifo_full = v.full;
    #1;
    chk({v.name, ".rdy"}, 32'(O_req_ready), 32'(v.rdy));
    @(posedge fe_clk);
    #1;
    chk({v.name, ".wr"},   32'(O_fifo_wr),     32'(v.wr));
    chk({v.name, ".data"}, 32'(O_fifo_data),   32'(v.dat));
    chk({v.name, ".lg"},   32'(O_last_grant),  32'(v.lg));
    chk({v.name, ".st"},   32'(O_state),       32'(v.st));
    chk({v.name, ".cnt"},  32'(O_stall_count), 32'(v.cnt));
    @(negedge fe_clk);
  endtask

  // Never a write while the FIFO reports full.
  always @(posedge fe_clk) begin
    #2;
    if (!reset_i) begin
      total++;
      if (O_fifo_wr && I_fifo_full) begin
        bad++;
        $display("FAIL wr_while_full: got wr=1 full=1 want wr=0");
      end
    end
  end

  initial begin
    logic [1:0] k;
    reset_i = 1'b1; I_enable = 1'b1; I_clear_stats = 1'b0; I_req_valid = 3'b111;
    I_fifo_full = 1'b0; I_fifo_prog_full = 1'b0;
    I_req_data = {D2, D1, D0};
    #2;
    chk("rst.rdy",  32'(O_req_ready),   32'd0);
    chk("rst.wr",   32'(O_fifo_wr),     32'd0);
    chk("rst.data", 32'(O_fifo_data),   32'd0);
    chk("rst.lg",   32'(O_last_grant),  32'd2);
    chk("rst.st",   32'(O_state),       32'd0);
    chk("rst.cnt",  32'(O_stall_count), 32'd0);

    vq.push_back(mk("idle2run", 1, 0, 3'b111, 0, 0, 3'b000, 0, 18'h0, 2'd2, 2'd1, 5'd0));
    for (int i = 0; i < 9; i++) begin
      k = 2'(i % 3);
      vq.push_back(mk("rr", 1, 0, 3'b111, 0, 0, 3'(1 << k), 1,
                      xw(k, (k == 2'd0) ? D0 : (k == 2'd1) ? D1 : D2), k, 2'd1, 5'd0));
    end
    for (int i = 0; i < 4; i++)
      vq.push_back(mk("solo1", 1, 0, 3'b010, 0, 0, 3'b010, 1, xw(2'd1, D1), 2'd1, 2'd1, 5'd0));
    for (int i = 0; i < 10; i++)
      vq.push_back(mk("pfull", 1, 0, 3'b001, 1, (i >= 3 && i <= 6), 3'b000, 0, xw(2'd1, D1),
                      2'd1, 2'd2, 5'(i + 1)));
    vq.push_back(mk("unblk",     1, 0, 3'b001, 0, 0, 3'b000, 0, xw(2'd1, D1), 2'd1, 2'd1, 5'd11));
    vq.push_back(mk("resume",    1, 0, 3'b001, 0, 0, 3'b001, 1, xw(2'd0, D0), 2'd0, 2'd1, 5'd11));
    vq.push_back(mk("en_drop",   0, 0, 3'b001, 0, 0, 3'b000, 0, xw(2'd0, D0), 2'd0, 2'd0, 5'd11));
    vq.push_back(mk("idle_off",  0, 0, 3'b001, 0, 0, 3'b000, 0, xw(2'd0, D0), 2'd0, 2'd0, 5'd11));
    vq.push_back(mk("clr_stall", 1, 1, 3'b001, 1, 0, 3'b000, 0, xw(2'd0, D0), 2'd0, 2'd1, 5'd0));
    vq.push_back(mk("blk_run",   1, 0, 3'b001, 1, 0, 3'b000, 0, xw(2'd0, D0), 2'd0, 2'd2, 5'd1));
    vq.push_back(mk("unblk_nv",  1, 0, 3'b000, 0, 0, 3'b000, 0, xw(2'd0, D0), 2'd0, 2'd1, 5'd1));
    vq.push_back(mk("run_nv",    1, 0, 3'b000, 0, 0, 3'b000, 0, xw(2'd0, D0), 2'd0, 2'd1, 5'd1));
    vq.push_back(mk("tag_r2",    1, 0, 3'b100, 0, 0, 3'b100, 1, xw(2'd2, D2), 2'd2, 2'd1, 5'd1));
    vq.push_back(mk("rr_wrap",   1, 0, 3'b101, 0, 0, 3'b001, 1, xw(2'd0, D0), 2'd0, 2'd1, 5'd1));
    vq.push_back(mk("rr_skip",   1, 0, 3'b101, 0, 0, 3'b100, 1, xw(2'd2, D2), 2'd2, 2'd1, 5'd1));

    @(negedge fe_clk);
    reset_i = 1'b0;
    foreach (vq[i]) apply(vq[i]);

    // Long stall drives the counter into saturation, then a clear pulse.
    for (int i = 0; i < 40; i++)
      apply(mk("sat", 1, 0, 3'b001, 1, 0, 3'b000, 0, xw(2'd2, D2), 2'd2, 2'd2,
               (i + 2 > 31) ? 5'd31 : 5'(i + 2)));
    apply(mk("sat_clr",  1, 1, 3'b001, 1, 0, 3'b000, 0, xw(2'd2, D2), 2'd2, 2'd2, 5'd0));
    apply(mk("pre_unblk", 1, 0, 3'b111, 0, 0, 3'b000, 0, xw(2'd2, D2), 2'd2, 2'd1, 5'd1));
    apply(mk("pre_acc",  1, 0, 3'b111, 0, 0, 3'b001, 1, xw(2'd0, D0), 2'd0, 2'd1, 5'd1));

    // Reset with a write pending: it is dropped at once and the pointer rewinds.
    reset_i = 1'b1;
    #1;
    chk("midrst.wr",   32'(O_fifo_wr),     32'd0);
    chk("midrst.lg",   32'(O_last_grant),  32'd2);
    chk("midrst.st",   32'(O_state),       32'd0);
    chk("midrst.data", 32'(O_fifo_data),   32'd0);
    chk("midrst.cnt",  32'(O_stall_count), 32'd0);
    @(negedge fe_clk);
    @(negedge fe_clk);
    reset_i = 1'b0;
    apply(mk("post_rst", 1, 0, 3'b111, 0, 0, 3'b000, 0, 18'h0, 2'd2, 2'd1, 5'd0));
    apply(mk("post_acc", 1, 0, 3'b111, 0, 0, 3'b001, 1, xw(2'd0, D0), 2'd0, 2'd1, 5'd0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
